pixel_pack: RTL

PIXEL_PACK -- requirements
Module: pixel_pack

---
 rtl/pixel_pack_pkg.sv | 32 +++
 rtl/pixel_pack.sv | 99 +++++++++
 2 files changed

// File: rtl/pixel_pack_pkg.sv
// Shared constants and types for the 6-bit pixel <-> byte packing path
// (used by pixel_pack and decomp3to4).
package pixel_pack_pkg;

  localparam int DWIDTH_C       = 8;
  localparam int CDEPTH_C       = 2;
  localparam int PWIDTH_C       = 3 * CDEPTH_C;
  localparam int GROUP_PIXELS_C = 4;
  localparam int GROUP_BYTES_C  = 3;
  localparam int ACC_W_C        = 16;
  localparam int CNT_W_C        = 5;
  localparam int GI_W_C         = 2;

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } pack_state_e;

  // Overwrite a 6-bit field of the accumulator starting at bit pos.
  function automatic logic [ACC_W_C-1:0] insert_pixel(
    input logic [ACC_W_C-1:0]  acc,
    input logic [PWIDTH_C-1:0] pix,
    input logic [CNT_W_C-1:0]  pos
  );
    logic [ACC_W_C-1:0] mask;
    logic [ACC_W_C-1:0] data;
    mask = 16'h003F << pos;
    data = {10'd0, pix} << pos;
    return (acc & ~mask) | data;
  endfunction

endpackage

// File: rtl/pixel_pack.sv
// Packs a stream of 6-bit pixels LSB-first into bytes (4 pixels -> 3 bytes),
// with a flush that zero-pads the current pixel group.
module pixel_pack
  import pixel_pack_pkg::*;
#(
  parameter int DWIDTH = 8,
  parameter int CDEPTH = 2
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic [3*CDEPTH-1:0]   PixelIn,
  input  logic                  PixelValid,
  output logic                  PixelReady,
  input  logic                  Flush,
  output logic [DWIDTH-1:0]     ByteOut,
  output logic                  ByteValid,
  input  logic                  ByteReady,
  output logic                  Busy
);

  pack_state_e         state_q, state_d;
  logic [ACC_W_C-1:0]  acc_q, acc_d;
  logic [CNT_W_C-1:0]  cnt_q, cnt_d;
  logic [GI_W_C-1:0]   gi_q, gi_d;

  logic                byte_xfer;
  logic                pix_xfer;
  logic [PWIDTH_C-1:0] pix_data;
  logic [CNT_W_C-1:0]  ins_pos;
  logic [ACC_W_C-1:0]  acc_base;

  // All handshake outputs come straight from registered state.
  assign ByteValid  = (cnt_q >= 5'd8);
  assign ByteOut    = acc_q[DWIDTH-1:0];
  assign PixelReady = (cnt_q <= 5'd10) && (state_q == ST_RUN);
  assign Busy       = (state_q == ST_FLUSH);

  always_comb begin
    byte_xfer = ByteValid && ByteReady;
    pix_xfer  = 1'b0;
    pix_data  = '0;
    state_d   = state_q;

    case (state_q)
      ST_RUN: begin
        pix_xfer = PixelValid && PixelReady;
        pix_data = PixelIn;
      end
      ST_FLUSH: begin
        pix_xfer = (cnt_q <= 5'd10) && (gi_q != 2'd0);
        pix_data = '0;
      end
      default: begin
        pix_xfer = 1'b0;
        pix_data = '0;
      end
    endcase

    // A byte leaving in the same cycle shifts first, so the new pixel lands 8 lower.
    acc_base = byte_xfer ? {8'd0, acc_q[ACC_W_C-1:8]} : acc_q;
    ins_pos  = byte_xfer ? (cnt_q - 5'd8) : cnt_q;
    acc_d    = pix_xfer ? insert_pixel(acc_base, pix_data, ins_pos) : acc_base;
    cnt_d    = cnt_q + (pix_xfer ? 5'd6 : 5'd0) - (byte_xfer ? 5'd8 : 5'd0);
    gi_d     = gi_q + (pix_xfer ? 2'd1 : 2'd0);

    case (state_q)
      ST_RUN: begin
        if (Flush && (gi_d != 2'd0)) begin
          state_d = ST_FLUSH;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_FLUSH: begin
        if ((gi_d == 2'd0) && (cnt_d == 5'd0)) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_FLUSH;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= ST_RUN;
      acc_q   <= '0;
      cnt_q   <= '0;
      gi_q    <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      gi_q    <= gi_d;
    end
  end

endmodule
